vram_scan_ctrl: RTL

VRAM_SCAN_CTRL -- requirements
Module: vram_scan_ctrl

---
 rtl/vram_scan_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_scan_ctrl.sv
// vram_scan_ctrl: raster scan generator and VRAM frame animator.
//
// Generates a VGA-style raster from a one-clk pixel strobe. The VRAM image
// is (H_ACTIVE/SCALE) x (V_ACTIVE/SCALE) pixels, and each VRAM pixel covers
// SCALE x SCALE screen pixels. A 2-bit frame select is advanced once per
// vertical frame, either automatically (loop or ping-pong, stretched by
// i_hold) or by single-step requests.
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_pix_en       one-clk pixel strobe; scan counters advance only here
//   i_anim_en      1 = automatic animation, 0 = frozen / single-step
//   i_mode         0 = loop 0..3, 1 = ping-pong 0..3..0
//   i_step         one-clk request to advance one frame (anim_en = 0)
//   i_hold [7:0]   vertical frames per animation frame (0 acts as 1)
//   o_address      VRAM pixel address row*128+col, 14'h3FFF when blanked
//   o_frame_count  VRAM frame select
//   o_hsync        active-low horizontal sync, one clk after the address
//   o_vsync        active-low vertical sync, one clk after the address
//   o_blank        1 outside the visible area, one clk after the address
module vram_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pix_en,
    input  logic        i_anim_en,
    input  logic        i_mode,
    input  logic        i_step,
    input  logic [7:0]  i_hold,
    output logic [13:0] o_address,
    output logic [1:0]  o_frame_count,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VIS_LS = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [SW-1:0] r_hsub;
    logic [SW-1:0] r_vsub;
    logic [6:0]    r_col;
    logic [6:0]    r_row;
    logic [13:0]   r_address;
    logic          r_blank_s1;
    logic          r_hsync_s1;
    logic          r_vsync_s1;
    logic          r_blank;
    logic          r_hsync;
    logic          r_vsync;
    logic [1:0]    r_frame;
    logic [7:0]    r_hold_cnt;
    logic          r_step_pend;
    logic          r_dir_up;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_vis;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_tick;
    logic [7:0]    w_hold_eff;
    logic [8:0]    w_hold_inc;
    logic          w_hold_done;
    logic          w_adv;
    logic          w_up;
    logic [1:0]    w_frame_nxt;
    logic          w_dir_nxt;

    assign w_h_wrap = (r_hcnt == H_LAST);
    assign w_v_wrap = (r_vcnt == V_LAST);
    assign w_vis    = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign w_hs_act = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
    assign w_vs_act = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
    // Last pixel of the last visible line: vcnt moves into vertical blank.
    assign w_tick   = i_pix_en && w_h_wrap && (r_vcnt == V_VIS_LS);

    // Scan counters; col/row are stepped by mod-SCALE sub-counters so the
    // address is a plain concatenation {row, col}.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hsub <= '0;
            r_vsub <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_pix_en) begin
            if (w_h_wrap) begin
                r_hcnt <= '0;
                r_hsub <= '0;
                r_col  <= '0;
                if (w_v_wrap) begin
                    r_vcnt <= '0;
                    r_vsub <= '0;
                    r_row  <= '0;
                end else begin
                    r_vcnt <= r_vcnt + 1'b1;
                    if (r_vcnt < V_VIS) begin
                        if (r_vsub == S_LAST) begin
                            r_vsub <= '0;
                            r_row  <= r_row + 7'd1;
                        end else begin
                            r_vsub <= r_vsub + 1'b1;
                        end
                    end
                end
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
                if (r_hcnt < H_VIS) begin
                    if (r_hsub == S_LAST) begin
                        r_hsub <= '0;
                        r_col  <= r_col + 7'd1;
                    end else begin
                        r_hsub <= r_hsub + 1'b1;
                    end
                end
            end
        end
    end

    // Address is registered on the strobe; the timing flags take one more
    // clk so they line up with VRAM data after its one-clk read latency.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_address  <= 14'h3FFF;
            r_blank_s1 <= 1'b1;
            r_hsync_s1 <= 1'b1;
            r_vsync_s1 <= 1'b1;
            r_blank    <= 1'b1;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else begin
            if (i_pix_en) begin
                r_address  <= w_vis ? {r_row, r_col} : 14'h3FFF;
                r_blank_s1 <= ~w_vis;
                r_hsync_s1 <= ~w_hs_act;
                r_vsync_s1 <= ~w_vs_act;
            end
            r_blank <= r_blank_s1;
            r_hsync <= r_hsync_s1;
            r_vsync <= r_vsync_s1;
        end
    end

    assign w_hold_eff  = (i_hold == 8'd0) ? 8'd1 : i_hold;
    assign w_hold_inc  = {1'b0, r_hold_cnt} + 9'd1;
    // >= rather than == so that lowering hold below the running count
    // advances on the very next tick.
    assign w_hold_done = (w_hold_inc >= {1'b0, w_hold_eff});
    assign w_adv       = w_tick && (i_anim_en ? w_hold_done : (r_step_pend || i_step));

    // Next frame select. In ping-pong the ends force the direction, so a
    // stale dir picked up after a mode change never walks off 0 or 3.
    always_comb begin
        w_up        = r_dir_up;
        w_frame_nxt = r_frame + 2'd1;
        w_dir_nxt   = r_dir_up;
        if (r_frame == 2'd0) begin
            w_up = 1'b1;
        end else if (r_frame == 2'd3) begin
            w_up = 1'b0;
        end
        if (i_mode) begin
            w_frame_nxt = w_up ? (r_frame + 2'd1) : (r_frame - 2'd1);
            if (w_frame_nxt == 2'd3) begin
                w_dir_nxt = 1'b0;
            end else if (w_frame_nxt == 2'd0) begin
                w_dir_nxt = 1'b1;
            end else begin
                w_dir_nxt = w_up;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame     <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_step_pend <= 1'b0;
            r_dir_up    <= 1'b1;
        end else begin
            if (w_tick) begin
                r_step_pend <= 1'b0;
            end else if (i_step) begin
                r_step_pend <= 1'b1;
            end
            if (w_tick && i_anim_en) begin
                r_hold_cnt <= w_hold_done ? 8'd0 : w_hold_inc[7:0];
            end
            if (w_adv) begin
                r_frame  <= w_frame_nxt;
                r_dir_up <= w_dir_nxt;
            end
        end
    end

    assign o_address     = r_address;
    assign o_frame_count = r_frame;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_blank       = r_blank;

endmodule
